pll_reset_tick: RTL
===================

# pll_reset_tick

Post-PLL clock-domain housekeeping block for the iCE40 designs: takes the PLL output clock and its raw `locked` flag, and produces a lock-qualified, glitch-free system reset. It also produces NCH independent, runtime-programmable clock-enable tick channels (baud, timer, refresh) and a saturating lock-loss counter. It sits directly after the PLL wrapper and feeds reset and tick enables to the CPU and peripherals.

## Interface
- `LOCK_SYNC`, 2: synchroniser flops on `locked` (≥2).
- `LOCK_STABLE`, 1024: cycles `locked` must stay high before reset release (≥1).
- `NCH`, 2: tick channels (1–8).
- `DIV_W`, 16: divisor width.
- `DIV_INIT`, {16'd18000, 16'd156}: packed NCH×DIV_W reset divisors, channel 0 in LSBs.
- `clock_in` in 1: PLL output clock, sole clock.
- `reset` in 1: asynchronous, active-high.
- `locked` in 1: raw PLL lock, asynchronous to `clock_in`.
- `div_wr` in 1: divisor write strobe.
- `div_sel` in $clog2(NCH) (min 1): target channel.
- `div_data` in DIV_W: new divisor.
- `loss_clr` in 1: clear lock-loss counter.
- `sys_reset` out 1: active-high system reset.
- `tick` out NCH: one-cycle enables.
- `loss_cnt` out 8: saturating lock-loss count.
- `running` out 1: state == RUN.

## Operation
- `locked` is passed through a LOCK_SYNC-flop synchroniser → `lock_s`.
- FSM states:
  - WAIT_LOCK (reset state): `lock_s`=1 → STABILISE, stable counter = 0.
  - STABILISE: counter increments each cycle. `lock_s`=0 → WAIT_LOCK, no loss count. Counter == LOCK_STABLE−1 → RUN.
  - RUN: `lock_s`=0 → WAIT_LOCK and `loss_cnt` increments, saturating at 255.
- `sys_reset` = (state != RUN), decoded from the state register, so assertion on `reset` is asynchronous.
- `running` = !`sys_reset`.
- Tick channel i:
  - Holds an active divisor, a shadow divisor and a counter `cnt`.
  - Outside RUN: `cnt` = 0, `tick[i]` = 0, and the shadow is copied into the active divisor every cycle.
  - In RUN: `tick[i]` = (`cnt` == eff−1), where eff = max(active, 1). On tick, `cnt` wraps to 0 and active ← shadow; otherwise `cnt` increments.
- Divisor writes:
  - `div_wr` writes `div_data` to shadow[`div_sel`].
  - A write in the same cycle as that channel's wrap is included in the reload; the new period starts immediately after that tick.
  - `div_sel` ≥ NCH: write ignored.
- A divisor of 0 behaves as 1: `tick` is high every RUN cycle.
- `loss_clr` zeroes `loss_cnt`. If `loss_clr` and an increment occur in the same cycle, the result is 1.
- Reset values: state WAIT_LOCK, `sys_reset`=1, `tick`=0, `loss_cnt`=0, `running`=0, shadow/active = DIV_INIT, all counters 0, synchroniser flops 0.
- `reset` mid-operation returns the block to WAIT_LOCK immediately. Written divisors are lost (back to DIV_INIT).

## Timing
- Lock-up: `locked` high from edge k (first sampling edge) → `sys_reset` falls after edge k+LOCK_SYNC+LOCK_STABLE.
- Lock loss: `locked` low sampled at edge k → `sys_reset` rises after edge k+LOCK_SYNC.
- First tick: channel with divisor D fires in the D-th RUN cycle (RUN entry cycle counts as 1). Thereafter it fires every D cycles.
- `loss_cnt` updates on the same edge as the RUN→WAIT_LOCK transition.
- `locked` glitches shorter than one clock may be missed. This is acceptable; the synchroniser handles metastability only.

## Structure
- Shared package `clkgen_pkg`:
  - FSM state enum {WAIT_LOCK, STABILISE, RUN}.
  - Loss-counter width constant (8).
  - Default DIV_INIT values for 18 MHz: 1 ms = 18000; 115200 baud ≈ 156.
- Sub-module `tick_div` (one channel: shadow, active, counter, tick) instantiated NCH times via generate.
- Top level holds the synchroniser, FSM, stable counter and loss counter.

## Test plan
- Reset release, LOCK_STABLE=16, `locked` rises at edge 10 → `sys_reset` falls after edge 28, `running`=1, `loss_cnt`=0.
- `locked` drops for 5 cycles during STABILISE → returns to WAIT_LOCK, stable count restarts, `loss_cnt` stays 0.
- `locked` drops in RUN three times, then `loss_clr` in the same cycle as a fourth loss → `loss_cnt` sequence 1, 2, 3, 1. Each drop asserts `sys_reset` LOCK_SYNC edges after sampling.
- Channel 1 divisor 4 in RUN, `div_wr` of 7 on the cycle of a tick → ticks at RUN cycles 4, 8, then 15, 22.
- Divisor 0 written while in WAIT_LOCK → `tick` high on every RUN cycle. Writing with `div_sel`=NCH leaves all divisors unchanged.
- Assert `reset` mid-RUN → `sys_reset`=1 and `tick`=0 asynchronously, divisors back to DIV_INIT, full lock-up sequence required again.

Source files
------------

// File: rtl/pll_reset_tick_pkg.sv
// Shared types and constants for the post-PLL reset/tick block.
// Default divisors assume an 18 MHz system clock.
package clkgen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int LOSS_W = 8;

    localparam logic [15:0] DIV_1MS_18MHZ         = 16'd18000;
    localparam logic [15:0] DIV_BAUD_115200_18MHZ = 16'd156;

    // Channel-select width; never narrower than one bit.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/pll_reset_tick_if.sv
// Divisor-programming / status bundle between the housekeeping block and its host.
// The master side programs divisors and clears the loss count; the slave reports reset, ticks and status.
interface pll_reset_tick_if #(
    parameter int NCH   = 2,
    parameter int DIV_W = 16
);
    localparam int SEL_W = clkgen_pkg::sel_width(NCH);

    logic                          div_wr;
    logic [SEL_W-1:0]              div_sel;
    logic [DIV_W-1:0]              div_data;
    logic                          loss_clr;
    logic                          sys_reset;
    logic [NCH-1:0]                tick;
    logic [clkgen_pkg::LOSS_W-1:0] loss_cnt;
    logic                          running;

    modport master (
        output div_wr, div_sel, div_data, loss_clr,
        input  sys_reset, tick, loss_cnt, running
    );

    modport slave (
        input  div_wr, div_sel, div_data, loss_clr,
        output sys_reset, tick, loss_cnt, running
    );

endinterface

// File: rtl/pll_reset_tick_tick_div.sv
// One clock-enable channel: shadow/active divisor pair and a wrap counter.
// Tick is combinational from registered state; a divisor of 0 behaves as 1.
module tick_div #(
    parameter int               DIV_W = 16,
    parameter logic [DIV_W-1:0] INIT  = '0
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             run,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdata,
    output logic             tick
);
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] shadow_nxt;
    logic [DIV_W-1:0] last;

    // A write landing on the wrap cycle is folded straight into the reload.
    assign shadow_nxt = wr ? wdata : shadow;
    assign last       = (active == '0) ? '0 : active - DIV_W'(1);
    assign tick       = run && (cnt == last);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            shadow <= INIT;
            active <= INIT;
            cnt    <= '0;
        end else begin
            shadow <= shadow_nxt;
            if (!run || tick) begin
                cnt    <= '0;
                active <= shadow_nxt;
            end else begin
                cnt    <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/pll_reset_tick.sv
// Lock-qualified system reset, NCH programmable tick channels and a saturating lock-loss counter.
// Reset asserts asynchronously on reset, LOCK_SYNC edges after lock loss; releases LOCK_SYNC+LOCK_STABLE edges after lock.
module pll_reset_tick
    import clkgen_pkg::*;
#(
    parameter int                     LOCK_SYNC   = 2,
    parameter int                     LOCK_STABLE = 1024,
    parameter int                     NCH         = 2,
    parameter int                     DIV_W       = 16,
    parameter logic [NCH*DIV_W-1:0]   DIV_INIT    = {DIV_1MS_18MHZ, DIV_BAUD_115200_18MHZ}
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              locked,
    pll_reset_tick_if.slave   bus
);
    localparam int SEL_W  = sel_width(NCH);
    localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);

    logic [LOCK_SYNC-1:0] sync_q;
    logic                 lock_s;
    state_t               state;
    logic [STAB_W-1:0]    stab_cnt;
    logic [LOSS_W-1:0]    loss_q;
    logic                 run;
    logic                 loss_event;
    logic [NCH-1:0]       tick_vec;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LOCK_SYNC-2:0], locked};
        end
    end

    assign lock_s = sync_q[LOCK_SYNC-1];

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state    <= STABILISE;
                        stab_cnt <= '0;
                    end
                end
                STABILISE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (stab_cnt == STAB_LAST) begin
                        state <= RUN;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    // Only a loss out of RUN counts; a clear racing an increment leaves 1.
    assign loss_event = (state == RUN) && !lock_s;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if (loss_event) begin
            if (bus.loss_clr) begin
                loss_q <= LOSS_W'(1);
            end else if (loss_q != '1) begin
                loss_q <= loss_q + LOSS_W'(1);
            end
        end else if (bus.loss_clr) begin
            loss_q <= '0;
        end
    end

    assign run           = (state == RUN);
    assign bus.sys_reset = !run;
    assign bus.running   = run;
    assign bus.loss_cnt  = loss_q;
    assign bus.tick      = tick_vec;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_div #(
            .DIV_W (DIV_W),
            .INIT  (DIV_INIT[i*DIV_W +: DIV_W])
        ) u_div (
            .clock_in (clock_in),
            .reset    (reset),
            .run      (run),
            .wr       (bus.div_wr && (bus.div_sel == SEL_W'(i))),
            .wdata    (bus.div_data),
            .tick     (tick_vec[i])
        );
    end

endmodule
